// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception resolver: flag bit positions,
// exception codes sent to CP0, CP0 register addresses and FSM states.
package exc_ctrl_pkg;

  localparam int F_ADEL_IF = 0;
  localparam int F_RI      = 1;
  localparam int F_OV      = 2;
  localparam int F_SYS     = 3;
  localparam int F_BP      = 4;
  localparam int F_ERET    = 5;
  localparam int F_ADEL_LD = 6;
  localparam int F_ADES    = 7;
  localparam int F_TLBL    = 8;
  localparam int F_TLBS    = 9;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_QUIET    = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [4:0] code;
    logic       is_refill;
    logic       is_load;
    logic       is_eret;
    logic       badv_pc;
    logic       badv_data;
  } prio_res_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle between the pipeline/CP0 and the exception resolver; names carry the
// resolver's own port direction suffix.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic [9:0]  mem_excFlags_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delay_slot_i;
  logic [31:0] mem_badVaddr_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] cp0_ebase_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] exceptionType_o;
  logic [31:0] exceptionAddr_o;
  logic        in_delay_slot_o;
  logic [31:0] badVaddr_o;
  logic        tlbmiss_o;
  logic        load_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] newPc_o;

  modport master (
    output mem_valid_i, mem_excFlags_i, mem_pc_i, mem_in_delay_slot_i, mem_badVaddr_i,
           int_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i, redirect_ready_i,
    input  exceptionType_o, exceptionAddr_o, in_delay_slot_o, badVaddr_o,
           tlbmiss_o, load_o, flush_o, redirect_valid_o, newPc_o
  );

  modport slave (
    input  mem_valid_i, mem_excFlags_i, mem_pc_i, mem_in_delay_slot_i, mem_badVaddr_i,
           int_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i, redirect_ready_i,
    output exceptionType_o, exceptionAddr_o, in_delay_slot_o, badVaddr_o,
           tlbmiss_o, load_o, flush_o, redirect_valid_o, newPc_o
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Picks the single highest-priority cause among a pending interrupt and the
// instruction's exception flags. EXC_TLB_REFILL_EN turns tlbl/tlbs into refills.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [9:0] flags_i,
  input  logic       int_i,
  output prio_res_t  res_o
);

  always_comb begin
    res_o      = '0;
    res_o.code = EXC_NONE;
    if (int_i) begin
      res_o.code = EXC_INT;
    end else if (flags_i[F_ADEL_IF]) begin
      res_o.code    = EXC_ADEL;
      res_o.badv_pc = 1'b1;
    end else if (flags_i[F_RI]) begin
      res_o.code = EXC_RI;
    end else if (flags_i[F_OV]) begin
      res_o.code = EXC_OV;
    end else if (flags_i[F_SYS]) begin
      res_o.code = EXC_SYS;
    end else if (flags_i[F_BP]) begin
      res_o.code = EXC_BP;
    end else if (flags_i[F_ERET]) begin
      res_o.code    = EXC_ERET;
      res_o.is_eret = 1'b1;
    end else if (flags_i[F_ADEL_LD]) begin
      res_o.code      = EXC_ADEL;
      res_o.badv_data = 1'b1;
    end else if (flags_i[F_TLBL]) begin
`ifdef EXC_TLB_REFILL_EN
      res_o.is_refill = 1'b1;
      res_o.is_load   = 1'b1;
`else
      res_o.code      = EXC_ADEL;
`endif
      res_o.badv_data = 1'b1;
    end else if (flags_i[F_ADES]) begin
      res_o.code      = EXC_ADES;
      res_o.badv_data = 1'b1;
    end else if (flags_i[F_TLBS]) begin
`ifdef EXC_TLB_REFILL_EN
      res_o.is_refill = 1'b1;
`else
      res_o.code      = EXC_ADES;
`endif
      res_o.badv_data = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception resolver: bypasses in-flight mtc0 writes, reports one exception
// per hit to CP0, flushes the pipe and holds the redirect PC. Option: EXC_TLB_REFILL_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter logic [31:0] GEN_OFS   = 32'h0000_0180,
  parameter int          QUIET_CYC = 1
) (
  input logic        clk,
  input logic        rst,
  exc_ctrl_if.slave  bus
);

  localparam int CNT_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [CNT_W-1:0] QUIET_LD = CNT_W'(QUIET_CYC - 1);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic [31:0]      type_q, type_d;
  logic [31:0]      addr_q, addr_d;
  logic             bd_q, bd_d;
  logic [31:0]      badv_q, badv_d;
  logic             tlbmiss_q, tlbmiss_d;
  logic             load_q, load_d;
  logic             flush_q, flush_d;
  logic [31:0]      newpc_q, newpc_d;

  logic [31:0] status_byp, cause_byp, epc_byp;
  logic [31:0] vec_base, vec_ofs;
  logic        int_pend, int_ok, hit;
  prio_res_t   res;
  logic        unused_bits;

  // Cause is only partly software-writable, so only IP[1:0] are bypassed.
  always_comb begin
    status_byp = bus.cp0_status_i;
    cause_byp  = bus.cp0_cause_i;
    epc_byp    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == CP0_STATUS) status_byp = bus.wb_cp0_wdata_i;
      if (bus.wb_cp0_waddr_i == CP0_CAUSE)  cause_byp[9:8] = bus.wb_cp0_wdata_i[9:8];
      if (bus.wb_cp0_waddr_i == CP0_EPC)    epc_byp = bus.wb_cp0_wdata_i;
    end
  end

  assign unused_bits = ^{cause_byp[31:10], cause_byp[7:0], status_byp[31:16], status_byp[7:2]};

  assign int_pend = status_byp[0] & ~status_byp[1] &
                    (|(status_byp[15:8] & {bus.int_i, cause_byp[9:8]}));
  assign int_ok   = int_pend & (state_q == ST_IDLE);
  assign hit      = bus.mem_valid_i & (state_q != ST_REDIRECT) &
                    ((|bus.mem_excFlags_i) | int_ok);

  exc_prio_enc u_prio (
    .flags_i (bus.mem_excFlags_i),
    .int_i   (int_ok),
    .res_o   (res)
  );

  assign vec_base = (bus.cp0_ebase_i == 32'h0) ? RESET_VEC : bus.cp0_ebase_i;
  assign vec_ofs  = (res.is_refill && !status_byp[1]) ? 32'h0 : GEN_OFS;

  always_comb begin
    state_d   = state_q;
    quiet_d   = quiet_q;
    type_d    = '0;
    addr_d    = '0;
    bd_d      = 1'b0;
    badv_d    = '0;
    tlbmiss_d = 1'b0;
    load_d    = 1'b0;
    flush_d   = 1'b0;
    newpc_d   = newpc_q;
    case (state_q)
      ST_IDLE: ;
      ST_REDIRECT: begin
        if (bus.redirect_ready_i) begin
          state_d = ST_QUIET;
          quiet_d = QUIET_LD;
        end
      end
      ST_QUIET: begin
        if (quiet_q == '0) state_d = ST_IDLE;
        else               quiet_d = quiet_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (hit) begin
      state_d   = ST_REDIRECT;
      type_d    = {27'h0, res.code};
      addr_d    = bus.mem_pc_i;
      bd_d      = res.is_eret ? 1'b0 : bus.mem_in_delay_slot_i;
      badv_d    = res.badv_pc   ? bus.mem_pc_i :
                  res.badv_data ? bus.mem_badVaddr_i : 32'h0;
      tlbmiss_d = res.is_refill;
      load_d    = res.is_load;
      flush_d   = 1'b1;
      newpc_d   = res.is_eret ? epc_byp : vec_base + vec_ofs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      quiet_q   <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      bd_q      <= 1'b0;
      badv_q    <= '0;
      tlbmiss_q <= 1'b0;
      load_q    <= 1'b0;
      flush_q   <= 1'b0;
      newpc_q   <= '0;
    end else begin
      state_q   <= state_d;
      quiet_q   <= quiet_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      bd_q      <= bd_d;
      badv_q    <= badv_d;
      tlbmiss_q <= tlbmiss_d;
      load_q    <= load_d;
      flush_q   <= flush_d;
      newpc_q   <= newpc_d;
    end
  end

  assign bus.exceptionType_o  = type_q;
  assign bus.exceptionAddr_o  = addr_q;
  assign bus.in_delay_slot_o  = bd_q;
  assign bus.badVaddr_o       = badv_q;
  assign bus.tlbmiss_o        = tlbmiss_q;
  assign bus.load_o           = load_q;
  assign bus.flush_o          = flush_q;
  assign bus.redirect_valid_o = (state_q == ST_REDIRECT);
  assign bus.newPc_o          = newpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed table-driven bench for exc_ctrl plus hand sequences for hold, quiet,
// same-cycle ready and reset during redirect. Follows EXC_TLB_REFILL_EN if defined.
module tb_exc_ctrl;

  localparam logic [31:0] EB = 32'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [9:0]  flags;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badv;
    logic [5:0]  intr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hit;
    logic [31:0] e_type;
    logic [31:0] e_addr;
    logic        e_bd;
    logic [31:0] e_badv;
    logic        e_tlbmiss;
    logic        e_load;
    logic [31:0] e_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exc_ctrl_if bus();

  exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic valid, logic [9:0] flags, logic [31:0] pc, logic bd,
                              logic [31:0] badv, logic [5:0] intr, logic [31:0] status,
                              logic [31:0] ebase, logic hit, logic [4:0] et, logic ebd,
                              logic [31:0] ebadv, logic [31:0] epc_exp);
    vec_t v;
    v = '0;
    v.valid = valid;  v.flags = flags;   v.pc = pc;     v.bd = bd;
    v.badv = badv;    v.intr = intr;     v.status = status;
    v.cause = 32'h0;  v.epc = 32'h8000_5000;  v.ebase = ebase;
    v.hit = hit;      v.e_type = {27'h0, et}; v.e_addr = hit ? pc : 32'h0;
    v.e_bd = ebd;     v.e_badv = ebadv;  v.e_pc = epc_exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.mem_valid_i         = v.valid;
    bus.mem_excFlags_i      = v.flags;
    bus.mem_pc_i            = v.pc;
    bus.mem_in_delay_slot_i = v.bd;
    bus.mem_badVaddr_i      = v.badv;
    bus.int_i               = v.intr;
    bus.cp0_status_i        = v.status;
    bus.cp0_cause_i         = v.cause;
    bus.cp0_epc_i           = v.epc;
    bus.cp0_ebase_i         = v.ebase;
    bus.wb_cp0_we_i         = v.wb_we;
    bus.wb_cp0_waddr_i      = v.wb_addr;
    bus.wb_cp0_wdata_i      = v.wb_data;
  endtask

  task automatic idle_in();
    drive(mk(1'b0, 10'h0, 32'h0, 1'b0, 32'h0, 6'h0, 32'h0, EB, 1'b0, 5'h0, 1'b0, 32'h0, 32'h0));
    bus.redirect_ready_i = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    drive(v);
    bus.redirect_ready_i = 1'b0;
    step();
    chk($sformatf("v%0d flush", i), {31'h0, bus.flush_o}, {31'h0, v.hit});
    chk($sformatf("v%0d rvalid", i), {31'h0, bus.redirect_valid_o}, {31'h0, v.hit});
    chk($sformatf("v%0d type", i), bus.exceptionType_o, v.e_type);
    chk($sformatf("v%0d addr", i), bus.exceptionAddr_o, v.e_addr);
    chk($sformatf("v%0d bd", i), {31'h0, bus.in_delay_slot_o}, {31'h0, v.e_bd});
    chk($sformatf("v%0d badv", i), bus.badVaddr_o, v.e_badv);
    chk($sformatf("v%0d tlbmiss", i), {31'h0, bus.tlbmiss_o}, {31'h0, v.e_tlbmiss});
    chk($sformatf("v%0d load", i), {31'h0, bus.load_o}, {31'h0, v.e_load});
    if (v.hit) chk($sformatf("v%0d newpc", i), bus.newPc_o, v.e_pc);
    idle_in();
    bus.redirect_ready_i = 1'b1;
    step();
    chk($sformatf("v%0d flush_drop", i), {31'h0, bus.flush_o}, 32'h0);
    chk($sformatf("v%0d rvalid_drop", i), {31'h0, bus.redirect_valid_o}, 32'h0);
    bus.redirect_ready_i = 1'b0;
    step();
    step();
  endtask

  vec_t vq[$];
  vec_t v;
  int   nflush;

  initial begin
    idle_in();
    #1;
    chk("rst type", bus.exceptionType_o, 32'h0);
    chk("rst flush", {31'h0, bus.flush_o}, 32'h0);
    chk("rst rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rst newpc", bus.newPc_o, 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    vq.push_back(mk(1, 10'h008, 32'h8000_1000, 0, 32'h0, 6'h0, 32'h0, EB, 1, 5'h08, 0, 32'h0, 32'h8000_0180));
    vq.push_back(mk(1, 10'h00C, 32'h8000_2004, 1, 32'hDEAD_BEEF, 6'h0, 32'h0, EB, 1, 5'h0c, 1, 32'h0, 32'h8000_0180));
    vq.push_back(mk(1, 10'h003, 32'h8000_0006, 0, 32'h1234_5678, 6'h0, 32'h0, EB, 1, 5'h04, 0, 32'h8000_0006, 32'h8000_0180));
    vq.push_back(mk(1, 10'h002, 32'h8000_0010, 1, 32'h0, 6'h0, 32'h0, EB, 1, 5'h0a, 1, 32'h0, 32'h8000_0180));
    vq.push_back(mk(1, 10'h030, 32'h8000_0020, 0, 32'h0, 6'h0, 32'h0, EB, 1, 5'h09, 0, 32'h0, 32'h8000_0180));
    vq.push_back(mk(1, 10'h020, 32'h8000_0030, 1, 32'h5555_0000, 6'h0, 32'h0, EB, 1, 5'h0e, 0, 32'h0, 32'h8000_5000));
    v = mk(1, 10'h020, 32'h8000_0034, 0, 32'h0, 6'h0, 32'h0, EB, 1, 5'h0e, 0, 32'h0, 32'h8000_3000);
    v.epc = 32'h8000_4000; v.wb_we = 1; v.wb_addr = 5'd14; v.wb_data = 32'h8000_3000;
    vq.push_back(v);
    vq.push_back(mk(1, 10'h0C0, 32'h8000_0040, 0, 32'h0000_0003, 6'h0, 32'h0, EB, 1, 5'h04, 0, 32'h0000_0003, 32'h8000_0180));
    vq.push_back(mk(1, 10'h080, 32'h8000_0044, 0, 32'h1000_0002, 6'h0, 32'h0, EB, 1, 5'h05, 0, 32'h1000_0002, 32'h8000_0180));
    vq.push_back(mk(1, 10'h008, 32'h8000_0050, 0, 32'h0, 6'h0, 32'h0, 32'h0, 1, 5'h08, 0, 32'h0, 32'hBFC0_0180));
    vq.push_back(mk(1, 10'h020, 32'h8000_0060, 1, 32'h0, 6'h01, 32'h0000_0401, EB, 1, 5'h01, 1, 32'h0, 32'h8000_0180));
    v = mk(1, 10'h000, 32'h8000_0070, 0, 32'h0, 6'h01, 32'h0, EB, 1, 5'h01, 0, 32'h0, 32'h8000_0180);
    v.wb_we = 1; v.wb_addr = 5'd12; v.wb_data = 32'h0000_0401;
    vq.push_back(v);
    vq.push_back(mk(1, 10'h000, 32'h8000_0074, 0, 32'h0, 6'h01, 32'h0000_0403, EB, 0, 5'h00, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 10'h000, 32'h8000_0078, 0, 32'h0, 6'h01, 32'h0000_0401, EB, 0, 5'h00, 0, 32'h0, 32'h0));
    v = mk(1, 10'h000, 32'h8000_0080, 0, 32'h0, 6'h00, 32'h0000_0101, EB, 1, 5'h01, 0, 32'h0, 32'h8000_0180);
    v.wb_we = 1; v.wb_addr = 5'd13; v.wb_data = 32'h0000_0100;
    vq.push_back(v);
    v = mk(1, 10'h000, 32'h8000_0084, 0, 32'h0, 6'h00, 32'h0000_0101, EB, 0, 5'h00, 0, 32'h0, 32'h0);
    v.wb_we = 1; v.wb_addr = 5'd13; v.wb_data = 32'hFFFF_FCFF;
    vq.push_back(v);
    vq.push_back(mk(0, 10'h008, 32'h8000_0088, 0, 32'h0, 6'h0, 32'h0, EB, 0, 5'h00, 0, 32'h0, 32'h0));
    v = mk(1, 10'h000, 32'h8000_008C, 0, 32'h0, 6'h01, 32'h0, EB, 0, 5'h00, 0, 32'h0, 32'h0);
    v.wb_we = 0; v.wb_addr = 5'd12; v.wb_data = 32'h0000_0401;
    vq.push_back(v);
`ifdef EXC_TLB_REFILL_EN
    v = mk(1, 10'h100, 32'h8000_0090, 0, 32'h0040_0010, 6'h0, 32'h0, EB, 1, 5'h00, 0, 32'h0040_0010, 32'h8000_0000);
    v.e_tlbmiss = 1; v.e_load = 1;
    vq.push_back(v);
    v = mk(1, 10'h200, 32'h8000_0094, 0, 32'h0040_0020, 6'h0, 32'h0000_0002, EB, 1, 5'h00, 0, 32'h0040_0020, 32'h8000_0180);
    v.e_tlbmiss = 1;
    vq.push_back(v);
`else
    vq.push_back(mk(1, 10'h100, 32'h8000_0090, 0, 32'h0040_0010, 6'h0, 32'h0, EB, 1, 5'h04, 0, 32'h0040_0010, 32'h8000_0180));
    vq.push_back(mk(1, 10'h200, 32'h8000_0094, 0, 32'h0040_0020, 6'h0, 32'h0000_0002, EB, 1, 5'h05, 0, 32'h0040_0020, 32'h8000_0180));
`endif

    foreach (vq[i]) run_vec(i, vq[i]);

    // Redirect held while IF stalls; new flags and interrupts ignored
    drive(mk(1, 10'h008, 32'h8000_1000, 0, 32'h0, 6'h0, 32'h0, EB, 1, 5'h08, 0, 32'h0, 32'h0));
    step();
    nflush = bus.flush_o ? 1 : 0;
    chk("hold first rvalid", {31'h0, bus.redirect_valid_o}, 32'h1);
    drive(mk(1, 10'h002, 32'h8000_2000, 0, 32'h0, 6'h01, 32'h0000_0401, 32'h9000_0000, 0, 5'h0, 0, 32'h0, 32'h0));
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.flush_o) nflush++;
      chk($sformatf("hold%0d rvalid", k), {31'h0, bus.redirect_valid_o}, 32'h1);
      chk($sformatf("hold%0d newpc", k), bus.newPc_o, 32'h8000_0180);
      chk($sformatf("hold%0d type", k), bus.exceptionType_o, 32'h0);
    end
    idle_in();
    bus.redirect_ready_i = 1'b1;
    step();
    chk("hold release rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("hold flush count", nflush, 1);
    bus.redirect_ready_i = 1'b0;
    step(); step();

    // Interrupt beats eret, then is masked for the quiet cycle
    drive(mk(1, 10'h020, 32'h8000_3000, 0, 32'h0, 6'h01, 32'h0000_0401, EB, 0, 5'h0, 0, 32'h0, 32'h0));
    bus.redirect_ready_i = 1'b1;
    step();
    chk("quiet int type", bus.exceptionType_o, 32'h1);
    bus.mem_excFlags_i = 10'h0;
    step();
    chk("quiet n2 flush", {31'h0, bus.flush_o}, 32'h0);
    step();
    chk("quiet n3 flush", {31'h0, bus.flush_o}, 32'h0);
    step();
    chk("quiet n4 flush", {31'h0, bus.flush_o}, 32'h1);
    chk("quiet n4 type", bus.exceptionType_o, 32'h1);
    idle_in();
    bus.redirect_ready_i = 1'b1;
    step();
    bus.redirect_ready_i = 1'b0;
    step(); step();

    // Same-cycle ready, then a synchronous flag taken during quiet
    drive(mk(1, 10'h008, 32'h8000_4000, 0, 32'h0, 6'h0, 32'h0, EB, 0, 5'h0, 0, 32'h0, 32'h0));
    bus.redirect_ready_i = 1'b1;
    step();
    chk("sc pulse type", bus.exceptionType_o, 32'h8);
    bus.mem_valid_i = 1'b0;
    step();
    chk("sc accepted rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = 32'h8000_4004;
    step();
    chk("sc quiet sync flush", {31'h0, bus.flush_o}, 32'h1);
    chk("sc quiet sync addr", bus.exceptionAddr_o, 32'h8000_4004);
    idle_in();
    bus.redirect_ready_i = 1'b1;
    step();
    bus.redirect_ready_i = 1'b0;
    step(); step();

    // Asynchronous reset while a redirect is outstanding
    drive(mk(1, 10'h008, 32'h8000_5000, 0, 32'h0, 6'h0, 32'h0, EB, 0, 5'h0, 0, 32'h0, 32'h0));
    step();
    chk("rstmid before rvalid", {31'h0, bus.redirect_valid_o}, 32'h1);
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk("rstmid rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rstmid flush", {31'h0, bus.flush_o}, 32'h0);
    chk("rstmid type", bus.exceptionType_o, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rstmid after rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
